// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter sequencer.
//   state_e         : sequencer states (BOOT, RUN, REDIR)
//   PC_STEP         : fetch address increment
//   DEF_RESET_PC    : default first fetch address
//   DEF_TRAP_VECTOR : default misaligned-target handler (PC_MISALIGN_TRAP_EN builds)
//   CNT_W           : width of the branch statistics counters
//   JALR_MASK       : clears bit 0 of a JALR target
//   ALIGN_MASK      : forces a target onto a word boundary
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } state_e;

  localparam logic [31:0] PC_STEP         = 32'd4;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0100;
  localparam int unsigned CNT_W           = 16;
  localparam logic [31:0] JALR_MASK       = 32'hFFFF_FFFE;
  localparam logic [31:0] ALIGN_MASK      = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_target_gen.sv
// Combinational control-transfer target computation.
//   is_jalr    in  : select (rs1_val+imm)&~1 instead of pc_ex+imm
//   pc_ex      in  : PC of the resolving instruction
//   imm        in  : sign-extended offset
//   rs1_val    in  : JALR base register
//   target     out : transfer target (word-aligned unless PC_MISALIGN_TRAP_EN)
//   misaligned out : target[1] set (only with PC_MISALIGN_TRAP_EN)
// Macro PC_MISALIGN_TRAP_EN: expose the raw target plus misaligned flag.
module pc_target_gen
  import pc_ctrl_pkg::*;
(
  input  logic        is_jalr,
  input  logic [31:0] pc_ex,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  output logic [31:0] target
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  logic [31:0] sum;
  logic [31:0] raw;

  always_comb begin
    sum = (is_jalr ? rs1_val : pc_ex) + imm;
    raw = is_jalr ? (sum & JALR_MASK) : sum;
`ifdef PC_MISALIGN_TRAP_EN
    target     = raw;
    misaligned = raw[1];
`else
    target     = raw & ALIGN_MASK;
`endif
  end

endmodule

// File: rtl/pc_controller.sv
// Program-counter sequencer: owns the PC, drives the fetch request with a
// valid/ready handshake, redirects on taken branches with a one-cycle flush,
// and keeps saturating branch statistics.
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall             : hazard hold, suppresses fetch and PC advance
//   branch_valid/taken, is_jalr, pc_ex, imm, rs1_val : EX-stage resolution
//   if_req/if_ready   : fetch handshake, pc_if the fetch address
//   flush             : kill IF/ID and ID/EX
//   branch_cnt/taken_cnt : saturating statistics
//   misalign_trap, trap_epc : misaligned-target trap (PC_MISALIGN_TRAP_EN only)
// Macro PC_MISALIGN_TRAP_EN enables the misaligned-target trap.
module pc_controller
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_valid,
  input  logic             branch_taken,
  input  logic             is_jalr,
  input  logic [31:0]      pc_ex,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1_val,
  output logic             if_req,
  input  logic             if_ready,
  output logic [31:0]      pc_if,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic             misalign_trap,
  output logic [31:0]      trap_epc
`endif
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             redirect;
  logic [31:0]      target;
`ifdef PC_MISALIGN_TRAP_EN
  logic             misaligned;
  logic             trap_q, trap_d;
  logic [31:0]      epc_q, epc_d;
`endif

  pc_target_gen u_target_gen (
    .is_jalr    (is_jalr),
    .pc_ex      (pc_ex),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .target     (target)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misaligned (misaligned)
`endif
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush_d  = 1'b0;
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    if_req   = 1'b0;
    redirect = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d   = 1'b0;
    epc_d    = epc_q;
`endif
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, REDIR: begin
        // Stall only gates the request; a redirect still wins over it.
        if_req   = (state_q == RUN) && !stall;
        redirect = branch_valid && branch_taken;
        if (branch_valid && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_W'(1);
        if (redirect && (tcnt_q != '1))     tcnt_d = tcnt_q + CNT_W'(1);
        if (redirect) begin
          state_d = REDIR;
          flush_d = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
          if (misaligned) begin
            pc_d   = TRAP_VECTOR;
            epc_d  = target;
            trap_d = 1'b1;
          end else begin
            pc_d   = target;
          end
`else
          pc_d    = target;
`endif
        end else begin
          state_d = RUN;
          if (if_req && if_ready) pc_d = pc_q + PC_STEP;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
      epc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q  <= trap_d;
      epc_q   <= epc_d;
`endif
    end
  end

  assign pc_if      = pc_q;
  assign flush      = flush_q;
  assign branch_cnt = bcnt_q;
  assign taken_cnt  = tcnt_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
  assign trap_epc      = epc_q;
`endif

endmodule

// File: tb/tb_pc_controller.sv
// Self-checking bench for pc_controller: directed vector table, async reset
// and counter saturation sequences, then randomized stimulus against a
// behavioural model. Honours PC_MISALIGN_TRAP_EN when defined.
module tb_pc_controller;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_valid, branch_taken, is_jalr, if_ready;
  logic [31:0] pc_ex, imm, rs1_val;
  logic        if_req, flush;
  logic [31:0] pc_if;
  logic [15:0] branch_cnt, taken_cnt;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] trap_epc;
`endif

  always #5 clk = ~clk;

  pc_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_taken (branch_taken),
    .is_jalr      (is_jalr),
    .pc_ex        (pc_ex),
    .imm          (imm),
    .rs1_val      (rs1_val),
    .if_req       (if_req),
    .if_ready     (if_ready),
    .pc_if        (pc_if),
    .flush        (flush),
    .branch_cnt   (branch_cnt),
    .taken_cnt    (taken_cnt)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign_trap(misalign_trap),
    .trap_epc     (trap_epc)
`endif
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // Behavioural model: "active" once the boot cycle has passed, "in_flush"
  // while the cycle after a taken transfer is being squashed.
  logic [31:0] m_pc;
  bit          m_active, m_flush;
  int unsigned m_bcnt, m_tcnt;
  bit          m_trap;
  logic [31:0] m_epc;
  bit          last_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = T_RESET_PC; m_active = 0; m_flush = 0;
    m_bcnt = 0; m_tcnt = 0; m_trap = 0; m_epc = '0;
  endtask

  task automatic set_in(input bit s, input bit bv, input bit bt, input bit j,
                        input bit rdy, input logic [31:0] pe, input logic [31:0] im,
                        input logic [31:0] r1);
    stall = s; branch_valid = bv; branch_taken = bt; is_jalr = j;
    if_ready = rdy; pc_ex = pe; imm = im; rs1_val = r1;
  endtask

  task automatic check_regs();
    chk("pc_if", pc_if, m_pc);
    chk("flush", {31'b0, flush}, {31'b0, m_flush});
    chk("branch_cnt", {16'b0, branch_cnt}, m_bcnt);
    chk("taken_cnt", {16'b0, taken_cnt}, m_tcnt);
`ifdef PC_MISALIGN_TRAP_EN
    chk("misalign_trap", {31'b0, misalign_trap}, {31'b0, m_trap});
    chk("trap_epc", trap_epc, m_epc);
`endif
  endtask

  // One clock cycle with the inputs currently applied.
  task automatic step();
    bit          exp_req;
    logic [31:0] t;
    #1;
    exp_req  = m_active && !m_flush && !stall;
    last_req = if_req;
    chk("if_req", {31'b0, if_req}, {31'b0, exp_req});
    @(posedge clk);
    if (!m_active) begin
      m_active = 1;
    end else begin
      if (branch_valid && m_bcnt < 65535) m_bcnt++;
      if (branch_valid && branch_taken && m_tcnt < 65535) m_tcnt++;
      m_trap = 0;
      if (branch_valid && branch_taken) begin
        t = is_jalr ? ((rs1_val + imm) & ~32'd1) : (pc_ex + imm);
`ifdef PC_MISALIGN_TRAP_EN
        if (t[1]) begin m_pc = T_TRAP_VEC; m_epc = t; m_trap = 1; end
        else m_pc = t;
`else
        m_pc = {t[31:2], 2'b00};
`endif
        m_flush = 1;
      end else begin
        m_flush = 0;
        if (exp_req && if_ready) m_pc = m_pc + 32'd4;
      end
    end
    #1;
    check_regs();
  endtask

  typedef struct {
    bit          s, bv, bt, j, rdy;
    logic [31:0] pe, im, r1;
    bit          exp_req;
    logic [31:0] exp_pc;
    bit          exp_flush;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit bv, input bit bt, input bit j,
                              input bit rdy, input logic [31:0] pe, input logic [31:0] im,
                              input logic [31:0] r1, input bit er, input logic [31:0] ep,
                              input bit ef);
    vec_t v;
    v.s = s; v.bv = bv; v.bt = bt; v.j = j; v.rdy = rdy;
    v.pe = pe; v.im = im; v.r1 = r1;
    v.exp_req = er; v.exp_pc = ep; v.exp_flush = ef;
    return v;
  endfunction

  vec_t vt[20];

  initial begin
    logic [31:0] p13;
`ifdef PC_MISALIGN_TRAP_EN
    p13 = 32'h100;
`else
    p13 = 32'h104;
`endif
    vt[0]  = mk(0,0,0,0,1, 0, 0, 0, 0, 32'h0, 0);
    vt[1]  = mk(0,0,0,0,1, 0, 0, 0, 1, 32'h4, 0);
    vt[2]  = mk(0,0,0,0,1, 0, 0, 0, 1, 32'h8, 0);
    vt[3]  = mk(0,0,0,0,1, 0, 0, 0, 1, 32'hC, 0);
    vt[4]  = mk(0,0,0,0,1, 0, 0, 0, 1, 32'h10, 0);
    vt[5]  = mk(0,0,0,0,0, 0, 0, 0, 1, 32'h10, 0);
    vt[6]  = mk(0,0,0,0,0, 0, 0, 0, 1, 32'h10, 0);
    vt[7]  = mk(0,0,0,0,0, 0, 0, 0, 1, 32'h10, 0);
    vt[8]  = mk(0,0,0,0,1, 0, 0, 0, 1, 32'h14, 0);
    vt[9]  = mk(1,1,1,0,1, 32'h20, 32'hFFFF_FFF8, 0, 0, 32'h18, 1);
    vt[10] = mk(0,0,0,0,1, 0, 0, 0, 0, 32'h18, 0);
    vt[11] = mk(0,0,0,0,1, 0, 0, 0, 1, 32'h1C, 0);
    vt[12] = mk(0,1,1,1,1, 0, 32'h4, 32'h101, 1, 32'h104, 1);
    vt[13] = mk(0,1,1,1,1, 0, 32'h5, 32'h101, 0, p13, 1);
    vt[14] = mk(0,0,0,0,0, 0, 0, 0, 0, p13, 0);
    vt[15] = mk(0,0,0,0,0, 0, 0, 0, 1, p13, 0);
    vt[16] = mk(0,1,0,0,1, 0, 0, 0, 1, p13 + 32'd4, 0);
    vt[17] = mk(0,1,1,0,1, 0, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 1);
    vt[18] = mk(0,0,0,0,1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
    vt[19] = mk(0,0,0,0,1, 0, 0, 0, 1, 32'h0, 0);

    // Reset state before any clock edge.
    rst_n = 1'b0;
    set_in(0,0,0,0,1, 0, 0, 0);
    model_reset();
    #3;
    chk("reset pc_if", pc_if, T_RESET_PC);
    chk("reset if_req", {31'b0, if_req}, 32'd0);
    check_regs();
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      set_in(vt[i].s, vt[i].bv, vt[i].bt, vt[i].j, vt[i].rdy, vt[i].pe, vt[i].im, vt[i].r1);
      step();
      chk($sformatf("vec%0d req", i), {31'b0, last_req}, {31'b0, vt[i].exp_req});
      chk($sformatf("vec%0d pc", i), pc_if, vt[i].exp_pc);
      chk($sformatf("vec%0d flush", i), {31'b0, flush}, {31'b0, vt[i].exp_flush});
`ifdef PC_MISALIGN_TRAP_EN
      if (i == 13) begin
        chk("vec13 trap", {31'b0, misalign_trap}, 32'd1);
        chk("vec13 epc", trap_epc, 32'h106);
      end
`endif
    end
    chk("table branch_cnt", {16'b0, branch_cnt}, 32'd5);
    chk("table taken_cnt", {16'b0, taken_cnt}, 32'd4);

    // Asynchronous reset in the middle of a redirect cycle.
    set_in(0,1,1,0,1, 32'h40, 32'h10, 0);
    step();
    set_in(0,0,0,0,1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async pc_if", pc_if, T_RESET_PC);
    chk("async flush", {31'b0, flush}, 32'd0);
    chk("async if_req", {31'b0, if_req}, 32'd0);
    chk("async branch_cnt", {16'b0, branch_cnt}, 32'd0);
    chk("async taken_cnt", {16'b0, taken_cnt}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("boot after release req", {31'b0, last_req}, 32'd0);
    step();
    chk("first fetch req", {31'b0, last_req}, 32'd1);

    // Counter saturation with not-taken branches.
    for (int i = 0; i < 65540; i++) begin
      set_in(1'($urandom_range(0, 1)), 1, 0, 0, 1, 0, 0, 0);
      step();
    end
    chk("sat branch_cnt", {16'b0, branch_cnt}, 32'h0000_FFFF);
    chk("sat taken_cnt", {16'b0, taken_cnt}, 32'd0);
    chk("sat flush", {31'b0, flush}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r_imm;
      r_imm = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 63)) - 32'd32);
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom, r_imm, $urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
